// File: rtl/rvcpu_pkg.sv
// ============================================================================
// Module : rvcpu_pkg
// Brief  : Shared types and constants for the rvcpu end-of-test monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rvcpu_pkg;

    typedef enum logic [1:0] {
        MON_RUN   = 2'd0,
        MON_DRAIN = 2'd1,
        MON_DONE  = 2'd2
    } mon_state_e;

    localparam logic [30:0] TOHOST_PASS_CODE = 31'd0;

endpackage

`default_nettype wire

// File: rtl/rvcpu_tohost_monitor.sv
// ============================================================================
// Module : rvcpu_tohost_monitor
// Brief  : Detects riscv-tests end of test (TOHOST store or ECALL/EBREAK
//          retire), latches a sticky result word and raises halted after a
//          short pipeline drain. Optional watchdog: define RVCPU_WATCHDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvcpu_tohost_monitor
    import rvcpu_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    input  logic        retire_valid,
    input  logic        halt_req,
    input  logic [31:0] a0_value,
    output logic        halted,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_test,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

    mon_state_e  state;
    mon_state_e  state_next;
    logic [3:0]  drain_cnt;
    logic        tohost_hit;
    logic        ecall_hit;
    logic        wdog_hit;
    logic        event_hit;
    logic        drain_done;
    logic [30:0] tohost_code;

    assign tohost_code = mem_wdata[31:1];
    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR) && (mem_be == 4'hF) && mem_wdata[0];
    assign ecall_hit   = retire_valid && halt_req;

`ifdef RVCPU_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
    // A real termination in the same cycle takes priority over the watchdog.
    assign wdog_hit = (cycle_count == WDOG_LAST) && !tohost_hit && !ecall_hit;
`else
    assign wdog_hit = 1'b0;
`endif

    assign event_hit  = tohost_hit || ecall_hit || wdog_hit;
    assign drain_done = (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MON_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MON_RUN:   if (event_hit)  state_next = MON_DRAIN;
            MON_DRAIN: if (drain_done) state_next = MON_DONE;
            MON_DONE:  state_next = MON_DONE;
            default:   state_next = MON_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted        <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            fail_test     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            drain_cnt     <= '0;
        end else begin
            if (state == MON_RUN) begin
                // Counters include the termination cycle, then freeze.
                cycle_count   <= cycle_count + 32'd1;
                instret_count <= instret_count + 32'(retire_valid);
                if (tohost_hit) begin
                    pass      <= (tohost_code == TOHOST_PASS_CODE);
                    fail_test <= tohost_code;
                end else if (ecall_hit) begin
                    pass      <= (a0_value == 32'd0);
                    fail_test <= a0_value[31:1];
                end else if (wdog_hit) begin
                    timeout   <= 1'b1;
                    pass      <= 1'b0;
                    fail_test <= '0;
                end
            end
            if (state == MON_DRAIN) begin
                if (drain_done) begin
                    halted <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire
